// File: rtl/fc10_score_accumulator_pkg.sv
// Shared constants, FSM state type and the 32-bit score saturation helper
// for the ten-class fully-connected score accumulator.
package fc_pkg;
    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 32;
    localparam int X_W_DEF     = 16;
    localparam int W_W_DEF     = 16;
    localparam int GUARD_DEF   = 8;

    typedef enum logic [1:0] {ACC, DRAIN, FIN} state_t;

    function automatic logic [SCORE_W-1:0] sat32(input logic signed [63:0] v);
        if (v > 64'sd2147483647)
            return 32'h7FFF_FFFF;
        else if (v < -64'sd2147483648)
            return 32'h8000_0000;
        else
            return v[SCORE_W-1:0];
    endfunction
endpackage

// File: rtl/fc_mac_lane.sv
// One class lane: registered product, wide accumulator, and the
// saturating bias add that produces the held score.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int X_W   = X_W_DEF,
    parameter int W_W   = W_W_DEF,
    parameter int GUARD = GUARD_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      take,
    input  logic                      fin,
    input  logic signed [X_W-1:0]     x,
    input  logic signed [W_W-1:0]     w,
    input  logic signed [SCORE_W-1:0] bias,
    output logic [SCORE_W-1:0]        score
);
    localparam int PW    = X_W + W_W;
    localparam int ACC_W = SCORE_W + GUARD;

    logic signed [PW-1:0]    p;
    logic                    pvld;
    logic signed [ACC_W-1:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p     <= '0;
            pvld  <= 1'b0;
            acc   <= '0;
            score <= '0;
        end else begin
            pvld <= take;
            if (take)
                p <= x * w;
            // No beat is accepted in DRAIN, so pvld is never set during FIN.
            if (fin) begin
                score <= sat32(64'(acc) + 64'(bias));
                acc   <= '0;
            end else if (pvld) begin
                acc <= acc + ACC_W'(p);
            end
        end
    end
endmodule

// File: rtl/fc10_score_accumulator.sv
// Frame FSM, beat counter and length check around ten MAC lanes; emits
// saturated per-class scores with a one-cycle strobe three cycles after the last beat.
module fc10_score_accumulator
    import fc_pkg::*;
#(
    parameter int N_IN  = 784,
    parameter int X_W   = X_W_DEF,
    parameter int W_W   = W_W_DEF,
    parameter int GUARD = GUARD_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_last,
    input  logic signed [X_W-1:0]                 x_in,
    input  logic [NUM_CLASSES-1:0][W_W-1:0]       w_in,
    input  logic [NUM_CLASSES-1:0][SCORE_W-1:0]   bias,
    output logic                                  output_valid,
    output logic [NUM_CLASSES-1:0][SCORE_W-1:0]   d_out,
    output logic                                  err_len
);
    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             take;
    logic             end_cnt;

    assign take    = in_valid & in_ready;
    assign end_cnt = (cnt == CNT_W'(N_IN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ACC;
            in_ready     <= 1'b0;
            output_valid <= 1'b0;
            err_len      <= 1'b0;
            cnt          <= '0;
            mismatch     <= 1'b0;
        end else begin
            output_valid <= 1'b0;
            case (state)
                ACC: begin
                    in_ready <= 1'b1;
                    if (take) begin
                        if (in_last || end_cnt) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                            // Length is good only when last and full count coincide.
                            mismatch <= in_last != end_cnt;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    state    <= FIN;
                    in_ready <= 1'b0;
                end
                FIN: begin
                    state        <= ACC;
                    in_ready     <= 1'b1;
                    output_valid <= 1'b1;
                    err_len      <= mismatch;
                    mismatch     <= 1'b0;
                    cnt          <= '0;
                end
                default: begin
                    state    <= ACC;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
        fc_mac_lane #(
            .X_W  (X_W),
            .W_W  (W_W),
            .GUARD(GUARD)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .take (take),
            .fin  (state == FIN),
            .x    (x_in),
            .w    ($signed(w_in[k])),
            .bias ($signed(bias[k])),
            .score(d_out[k])
        );
    end
endmodule

// File: tb/tb_fc10_score_accumulator.sv
// Randomized and directed bench: beats feed a frame-level sum model, and a
// negedge monitor checks ready/strobe timing and scores per result.
module tb_fc10_score_accumulator;
    import fc_pkg::*;

    localparam int N = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic                     in_last = 1'b0;
    logic signed [15:0]       x_in = '0;
    logic [9:0][15:0]         w_in = '0;
    logic [9:0][31:0]         bias = '0;
    logic                     output_valid;
    logic [9:0][31:0]         d_out;
    logic                     err_len;

    fc10_score_accumulator #(.N_IN(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .x_in(x_in), .w_in(w_in), .bias(bias),
        .output_valid(output_valid), .d_out(d_out), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int               tcyc;
        logic [9:0][31:0] sc;
        logic             err;
    } exp_t;

    exp_t   q[$];
    longint fsum[10];
    int     fcnt = 0;

    function automatic logic [31:0] sat(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 10; k++) fsum[k] = 0;
        fcnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int xv, input int wv[10], input bit last);
        int   t = 0;
        int   tc;
        exp_t e;
        while (!in_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_last  = last;
        x_in     = 16'(xv);
        for (int k = 0; k < 10; k++) w_in[k] = 16'(wv[k]);
        tc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        x_in     = 16'($urandom);
        for (int k = 0; k < 10; k++) w_in[k] = 16'($urandom);
        for (int k = 0; k < 10; k++) fsum[k] += longint'(xv) * longint'(wv[k]);
        fcnt++;
        if (last || fcnt == N) begin
            e.tcyc = tc;
            for (int k = 0; k < 10; k++)
                e.sc[k] = sat(fsum[k] + longint'($signed(bias[k])));
            e.err = !(last && fcnt == N);
            q.push_back(e);
            model_clear();
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (q.size() != 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", q.size(), 0);
        idle(1);
    endtask

    // Timing and score monitor relative to the terminating beat's cycle.
    int md;
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0) begin
                md = cyc - q[0].tcyc;
                if (md == 1 || md == 2) chk("ready_low", in_ready, 0);
                if (md == 3) begin
                    chk("strobe", output_valid, 1);
                    chk("ready_back", in_ready, 1);
                    for (int k = 0; k < 10; k++)
                        chk($sformatf("d_out%0d", k), d_out[k], q[0].sc[k]);
                    chk("err_len", err_len, q[0].err);
                    void'(q.pop_front());
                end else if (output_valid) begin
                    chk("spurious_valid", output_valid, 0);
                end
            end else if (output_valid) begin
                chk("spurious_valid", output_valid, 0);
            end
        end
    end

    int wv[10];
    int w1[10];

    initial begin
        model_clear();
        for (int k = 0; k < 10; k++) w1[k] = 1;

        // Reset state
        @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", output_valid, 0);
        for (int k = 0; k < 10; k++) chk($sformatf("rst_d%0d", k), d_out[k], 0);
        chk("rst_err", err_len, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", in_ready, 1);

        // Linear frame, bias 0
        for (int k = 0; k < 10; k++) wv[k] = k + 1;
        for (int i = 1; i <= 4; i++) beat(i, wv, i == 4);
        wait_idle();

        // Bias -5, random gaps, back-to-back frames
        for (int k = 0; k < 10; k++) bias[k] = 32'(-5);
        for (int f = 0; f < 2; f++)
            for (int i = 1; i <= 4; i++) begin
                if (i != 1) idle($urandom_range(0, 3));
                beat(i, wv, i == 4);
            end
        wait_idle();

        // Saturation, both directions
        for (int k = 0; k < 10; k++) bias[k] = '0;
        for (int k = 0; k < 10; k++) wv[k] = 32767;
        for (int i = 1; i <= 4; i++) beat(32767, wv, i == 4);
        for (int i = 1; i <= 4; i++) beat(-32768, wv, i == 4);
        wait_idle();

        // Short frame, then full-count frame without in_last
        for (int i = 1; i <= 2; i++) beat(1, w1, i == 2);
        for (int i = 1; i <= 4; i++) beat(1, w1, 1'b0);
        wait_idle();

        // Mid-frame reset drops the partial frame
        beat(7, w1, 1'b0);
        beat(9, w1, 1'b0);
        idle(1);
        rst = 1'b1;
        model_clear();
        #3;
        chk("midrst_d0", d_out[0], 0);
        rst = 1'b0;
        idle(2);
        for (int i = 1; i <= 4; i++) beat(i, w1, i == 4);
        wait_idle();

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            int nb;
            bit lst;
            if (f % 5 == 0) begin
                wait_idle();
                for (int k = 0; k < 10; k++) bias[k] = $urandom;
            end
            nb  = $urandom_range(1, 4);
            lst = (nb < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 1; i <= nb; i++) begin
                int xv;
                for (int k = 0; k < 10; k++) wv[k] = int'($signed(16'($urandom)));
                xv = int'($signed(16'($urandom)));
                idle($urandom_range(0, 2));
                beat(xv, wv, lst && i == nb);
            end
        end
        wait_idle();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
